// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one sequential 8x8 multiplier (start/done handshake, 16-bit product)
//   between NREQ requesters. A round-robin arbiter picks a requester, latches
//   its operands, pulses mult_start and waits for mult_done. The product goes
//   back to the owning requester. A watchdog ends the wait with an error
//   response if done never arrives.
//
// Ports
//   clk           rising-edge clock
//   reset_a       synchronous active-high reset
//   req           per-requester request level
//   a_in, b_in    packed operands, requester i at bits [8i+7:8i]
//   gnt           one-hot grant pulse (operands captured)
//   rsp_valid     one-hot response pulse
//   rsp_product   product, valid with rsp_valid, held until the next response
//   rsp_err       watchdog timeout flag, valid with rsp_valid
//   busy          high whenever the controller is not idle
//   mult_start    one-cycle start pulse to the multiplier
//   mult_a/mult_b operands to the multiplier, stable from grant to response
//   mult_done     multiplier completion (only honoured while waiting)
//   mult_product  multiplier result
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] a_in,
  input  logic [8*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic              mult_start,
  output logic [7:0]        mult_a,
  output logic [7:0]        mult_b,
  input  logic              mult_done,
  input  logic [15:0]       mult_product
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] PTR_RST  = IDXW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Round-robin search: first set request strictly after ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] p);
    logic            found;
    logic [IDXW-1:0] idx;
    int              cand;
    found = 1'b0;
    idx   = {IDXW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(p) + k) % NREQ;
      if (!found && r[IDXW'(cand)]) begin
        found = 1'b1;
        idx   = IDXW'(cand);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [IDXW-1:0] idx);
    return ONE_HOT0 << idx;
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [IDXW-1:0] ptr_r;
  logic [IDXW-1:0] owner_r;
  logic [WDW-1:0]  wd_r;
  logic [IDXW:0]   pick_s;
  logic            pick_valid_s;
  logic [IDXW-1:0] pick_idx_s;

  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [15:0]     rsp_product_r;
  logic            rsp_err_r;
  logic            busy_r;
  logic            mult_start_r;
  logic [7:0]      mult_a_r;
  logic [7:0]      mult_b_r;

  assign pick_s       = rr_pick(req, ptr_r);
  assign pick_valid_s = pick_s[IDXW];
  assign pick_idx_s   = pick_s[IDXW-1:0];

  assign gnt         = gnt_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_product = rsp_product_r;
  assign rsp_err     = rsp_err_r;
  assign busy        = busy_r;
  assign mult_start  = mult_start_r;
  assign mult_a      = mult_a_r;
  assign mult_b      = mult_b_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; done has priority over the watchdog in the last cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_valid_s) begin
          state_next_s = S_GRANT;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_GRANT: state_next_s = S_START;
      S_START: state_next_s = S_WAIT;
      S_WAIT: begin
        if (mult_done) begin
          state_next_s = S_RESP;
        end else if (wd_r == WD_LAST) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_RESP:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; pulses are rebuilt every cycle.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      ptr_r         <= PTR_RST;
      owner_r       <= {IDXW{1'b0}};
      wd_r          <= {WDW{1'b0}};
      gnt_r         <= {NREQ{1'b0}};
      rsp_valid_r   <= {NREQ{1'b0}};
      rsp_product_r <= 16'h0000;
      rsp_err_r     <= 1'b0;
      busy_r        <= 1'b0;
      mult_start_r  <= 1'b0;
      mult_a_r      <= 8'h00;
      mult_b_r      <= 8'h00;
    end else begin
      gnt_r        <= {NREQ{1'b0}};
      rsp_valid_r  <= {NREQ{1'b0}};
      mult_start_r <= 1'b0;
      busy_r       <= (state_next_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (pick_valid_s) begin
            owner_r  <= pick_idx_s;
            mult_a_r <= a_in[{pick_idx_s, 3'b000} +: 8];
            mult_b_r <= b_in[{pick_idx_s, 3'b000} +: 8];
            gnt_r    <= one_hot(pick_idx_s);
          end
        end
        S_GRANT: begin
          mult_start_r <= 1'b1;
        end
        S_START: begin
          wd_r <= {WDW{1'b0}};
        end
        S_WAIT: begin
          if (mult_done) begin
            rsp_product_r <= mult_product;
            rsp_err_r     <= 1'b0;
            rsp_valid_r   <= one_hot(owner_r);
          end else if (wd_r == WD_LAST) begin
            rsp_product_r <= 16'h0000;
            rsp_err_r     <= 1'b1;
            rsp_valid_r   <= one_hot(owner_r);
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        S_RESP: begin
          ptr_r <= owner_r;
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              reset_a;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_in;
  logic [8*NREQ-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_product;
  logic              rsp_err;
  logic              busy;
  logic              mult_start;
  logic [7:0]        mult_a;
  logic [7:0]        mult_b;
  logic              mult_done;
  logic [15:0]       mult_product;

  int   cyc;
  int   n_tests;
  int   n_fail;
  int   ref_ptr;
  int   mdl_delay;
  int   mdl_cnt;
  bit   mdl_never;
  logic [15:0] mdl_p;

  typedef struct {
    int              t_gnt;
    logic [NREQ-1:0] g;
    int              t_start;
    int              n_start;
    int              t_rsp;
    logic [NREQ-1:0] rv;
    logic [15:0]     prod;
    logic            err;
    logic [7:0]      ma;
    logic [7:0]      mb;
    bit              stable;
    bit              busy_ok;
  } op_t;

  mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_done    (mult_done),
    .mult_product (mult_product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done pulse mdl_delay cycles after the start cycle.
  initial begin
    mult_done    = 1'b0;
    mult_product = 16'h0000;
    mdl_cnt      = 0;
    forever begin
      @(negedge clk);
      mult_done = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mult_done    = 1'b1;
          mult_product = mdl_p;
        end
      end
      if (mult_start && !mdl_never) begin
        mdl_cnt = mdl_delay;
        mdl_p   = 16'(mult_a) * 16'(mult_b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  // Reference round-robin: first requester after the last owner, wrapping.
  function automatic int ref_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[8*i +: 8] = a;
    b_in[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_a = 1'b1;
    req     = '0;
    @(negedge clk);
    reset_a = 1'b0;
    ref_ptr = NREQ - 1;
  endtask

  // Observe one operation from grant to response (bounded by budget).
  task automatic wait_op(input int budget, input bit drop, input bit scramble, output op_t o);
    bit fin;
    o.t_gnt = -1; o.t_start = -1; o.t_rsp = -1; o.n_start = 0;
    o.g = '0; o.rv = '0; o.prod = 16'h0000; o.err = 1'b0;
    o.ma = 8'h00; o.mb = 8'h00; o.stable = 1'b1; o.busy_ok = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      if (o.t_gnt >= 0 && (mult_a !== o.ma || mult_b !== o.mb)) o.stable = 1'b0;
      if (o.t_gnt >= 0 && busy !== 1'b1) o.busy_ok = 1'b0;
      if (gnt != '0 && o.t_gnt < 0) begin
        o.t_gnt = cyc; o.g = gnt; o.ma = mult_a; o.mb = mult_b;
        if (busy !== 1'b1) o.busy_ok = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
          if (gnt[j] && scramble) set_ops(j, ~a_in[8*j +: 8], ~b_in[8*j +: 8]);
        end
        if (drop) req = req & ~gnt;
      end
      if (mult_start === 1'b1) begin
        o.n_start++;
        if (o.t_start < 0) o.t_start = cyc;
      end
      if (rsp_valid != '0) begin
        o.t_rsp = cyc; o.rv = rsp_valid; o.prod = rsp_product; o.err = rsp_err;
        fin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1;
    req = '0; a_in = '0; b_in = '0;
    mdl_never = 1'b0; mdl_delay = 5;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b rsp_valid=%b prod=%h err=%b busy=%b start=%b a=%h b=%h, required all 0",
               gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b);
    end
    set_ops(0, 8'h12, 8'h34);
    req = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins: gnt=%b busy=%b, required gnt=0000 busy=0", gnt, busy);
    end
    req = '0;
    reset_a = 1'b0;
    ref_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    op_t o; int t0;
    @(negedge clk);
    mdl_never = 1'b0; mdl_delay = 5;
    set_ops(2, 8'h0F, 8'h11);
    req = 4'b0100; t0 = cyc;
    wait_op(40, 1'b1, 1'b0, o);
    req = '0;
    n_tests++;
    if (o.g !== 4'b0100 || o.t_gnt !== t0 + 1) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b at +%0d, required 0100 at +1", o.g, o.t_gnt - t0);
    end
    n_tests++;
    if (o.n_start !== 1 || o.t_start !== t0 + 2) begin
      n_fail++;
      $display("FAIL single_start: %0d pulses first at +%0d, required 1 at +2", o.n_start, o.t_start - t0);
    end
    n_tests++;
    if (o.rv !== 4'b0100 || o.t_rsp !== t0 + 8 || o.prod !== 16'h00FF || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: rv=%b at +%0d prod=%h err=%b, required 0100 at +8 prod=00ff err=0",
               o.rv, o.t_rsp - t0, o.prod, o.err);
    end
    n_tests++;
    if (!o.busy_ok) begin
      n_fail++;
      $display("FAIL single_busy: busy low during operation, required high");
    end
    ref_ptr = 2;
  endtask

  task automatic test_round_robin();
    op_t o; int w; int prev_rsp; logic [7:0] v; logic [15:0] ep;
    do_reset();
    @(negedge clk);
    mdl_never = 1'b0; mdl_delay = 5;
    for (int i = 0; i < NREQ; i++) begin
      v = 8'(i * 16 + 1);
      set_ops(i, v, v);
    end
    req = 4'b1111;
    prev_rsp = -1;
    for (int n = 0; n < 5; n++) begin
      w = ref_pick(4'b1111, ref_ptr);
      v = 8'(w * 16 + 1);
      ep = 16'(v) * 16'(v);
      wait_op(40, 1'b0, 1'b0, o);
      n_tests++;
      if (o.g !== oh(w) || o.rv !== oh(w) || o.prod !== ep) begin
        n_fail++;
        $display("FAIL rr_op%0d: gnt=%b rv=%b prod=%h, required gnt=rv=%b prod=%h",
                 n, o.g, o.rv, o.prod, oh(w), ep);
      end
      if (n > 0) begin
        n_tests++;
        if (o.t_rsp - prev_rsp !== 9) begin
          n_fail++;
          $display("FAIL rr_spacing%0d: %0d cycles between responses, required 9", n, o.t_rsp - prev_rsp);
        end
      end
      prev_rsp = o.t_rsp;
      ref_ptr = w;
    end
    req = '0;
  endtask

  task automatic test_boundary();
    op_t o;
    logic [7:0]  ta [2];
    logic [7:0]  tb [2];
    logic [15:0] tp [2];
    ta[0] = 8'hFF; tb[0] = 8'hFF; tp[0] = 16'hFE01;
    ta[1] = 8'h00; tb[1] = 8'hAB; tp[1] = 16'h0000;
    mdl_never = 1'b0; mdl_delay = 5;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      set_ops(3, ta[n], tb[n]);
      req = 4'b1000;
      wait_op(40, 1'b1, 1'b0, o);
      req = '0;
      n_tests++;
      if (o.rv !== 4'b1000 || o.prod !== tp[n] || o.err !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary%0d: rv=%b prod=%h err=%b, required 1000 prod=%h err=0",
                 n, o.rv, o.prod, o.err, tp[n]);
      end
      ref_ptr = 3;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    op_t o; int t0;
    @(negedge clk);
    mdl_never = 1'b1;
    set_ops(0, 8'h07, 8'h09);
    req = 4'b0001; t0 = cyc;
    wait_op(60, 1'b1, 1'b0, o);
    req = '0;
    n_tests++;
    if (o.rv !== 4'b0001 || o.t_start !== t0 + 2 || o.t_rsp !== o.t_start + TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_timing: rv=%b start +%0d rsp +%0d, required 0001 start +2 rsp +%0d",
               o.rv, o.t_start - t0, o.t_rsp - t0, 2 + TIMEOUT + 1);
    end
    n_tests++;
    if (o.err !== 1'b1 || o.prod !== 16'h0000) begin
      n_fail++;
      $display("FAIL timeout_flag: err=%b prod=%h, required err=1 prod=0000", o.err, o.prod);
    end
    ref_ptr = 0;
    @(negedge clk);
    mdl_never = 1'b0; mdl_delay = 5;
    set_ops(1, 8'h0B, 8'h0D);
    req = 4'b0010;
    wait_op(40, 1'b1, 1'b0, o);
    req = '0;
    n_tests++;
    if (o.rv !== 4'b0010 || o.err !== 1'b0 || o.prod !== 16'h008F || o.n_start !== 1) begin
      n_fail++;
      $display("FAIL timeout_recover: rv=%b err=%b prod=%h starts=%0d, required 0010 err=0 prod=008f starts=1",
               o.rv, o.err, o.prod, o.n_start);
    end
    ref_ptr = 1;
  endtask

  task automatic test_random();
    op_t o; int w; logic [NREQ-1:0] m; logic [7:0] ea; logic [7:0] eb; logic [15:0] ep;
    mdl_never = 1'b0;
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
      w  = ref_pick(m, ref_ptr);
      ea = a_in[8*w +: 8];
      eb = b_in[8*w +: 8];
      ep = 16'(ea) * 16'(eb);
      mdl_delay = $urandom_range(1, 12);
      req = m;
      wait_op(40, 1'b1, 1'b0, o);
      req = '0;
      n_tests++;
      if (o.g !== oh(w) || o.rv !== oh(w) || o.prod !== ep || o.err !== 1'b0 ||
          o.t_rsp !== o.t_start + mdl_delay + 1) begin
        n_fail++;
        $display("FAIL random%0d: req=%b gnt=%b rv=%b prod=%h err=%b lat=%0d, required gnt=rv=%b prod=%h err=0 lat=%0d",
                 it, m, o.g, o.rv, o.prod, o.err, o.t_rsp - o.t_start, oh(w), ep, mdl_delay + 1);
      end
      ref_ptr = w;
    end
  endtask

  task automatic test_reset_mid();
    op_t o; int n_rsp; int n_busy;
    @(negedge clk);
    mdl_never = 1'b0; mdl_delay = 8;
    set_ops(0, 8'h5A, 8'h3C);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: gnt=%b rsp_valid=%b prod=%h err=%b busy=%b start=%b a=%h b=%h, required all 0",
               gnt, rsp_valid, rsp_product, rsp_err, busy, mult_start, mult_a, mult_b);
    end
    reset_a = 1'b0;
    ref_ptr = NREQ - 1;
    n_rsp = 0; n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) n_rsp++;
      if (busy !== 1'b0) n_busy++;
    end
    n_tests++;
    if (n_rsp !== 0 || n_busy !== 0) begin
      n_fail++;
      $display("FAIL stale_done: %0d responses %0d busy cycles, required 0 and 0", n_rsp, n_busy);
    end
    set_ops(1, 8'h03, 8'h05);
    set_ops(3, 8'h02, 8'h02);
    req = 4'b1010;
    wait_op(40, 1'b1, 1'b0, o);
    req = '0;
    n_tests++;
    if (o.g !== 4'b0010 || o.prod !== 16'h000F) begin
      n_fail++;
      $display("FAIL midreset_first: gnt=%b prod=%h, required 0010 prod=000f", o.g, o.prod);
    end
    ref_ptr = 1;
  endtask

  task automatic test_operand_stability();
    op_t o;
    @(negedge clk);
    mdl_never = 1'b0; mdl_delay = 6;
    set_ops(2, 8'h12, 8'h34);
    req = 4'b0100;
    wait_op(40, 1'b1, 1'b1, o);
    req = '0;
    n_tests++;
    if (!o.stable || o.ma !== 8'h12 || o.mb !== 8'h34 || o.prod !== 16'h03A8) begin
      n_fail++;
      $display("FAIL operand_stability: stable=%0d a=%h b=%h prod=%h, required 1 12 34 03a8",
               o.stable, o.ma, o.mb, o.prod);
    end
    ref_ptr = 2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_timeout();
    test_random();
    test_reset_mid();
    test_operand_stability();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
